// File: rtl/cpu_pkg.sv
// Shared CPU-wide definitions: cell command encodings and the default cell/address widths
// used by both the ram block and the cell access unit.
package cpu_pkg;

  localparam int ADDR_BITS = 16;
  localparam int DATA_BITS = 8;

  typedef enum logic [1:0] {
    OP_READ  = 2'b00,
    OP_WRITE = 2'b01,
    OP_ADD   = 2'b10,
    OP_CLEAR = 2'b11
  } op_e;

endpackage

// File: rtl/cell_access_unit_if.sv
// Command/response handshake between the core datapath (master) and the cell access unit (slave).
// Both directions use valid/ready; a transfer happens on a clock edge where both are high.
interface cell_access_unit_if #(
  parameter int addr_bits = 16,
  parameter int data_bits = 8
);
  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [1:0]           cmd_op;
  logic [addr_bits-1:0] cmd_address;
  logic [data_bits-1:0] cmd_data;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [data_bits-1:0] rsp_data;
  logic                 rsp_zero;

  modport master (
    output cmd_valid, cmd_op, cmd_address, cmd_data, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data, rsp_zero
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_address, cmd_data, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data, rsp_zero
  );
endinterface

// File: rtl/ram.sv
// Single-port cell memory; data_out reflects the addressed cell read_latency cycles after the
// address is stable (latency 1 is an asynchronous read). Writes land on the rising edge.
module ram #(
  parameter int addr_bits    = 16,
  parameter int data_bits    = 8,
  parameter int read_latency = 1
) (
  input  logic                 clock,
  input  logic [addr_bits-1:0] address,
  input  logic                 write_enable,
  input  logic [data_bits-1:0] data_in,
  output logic [data_bits-1:0] data_out
);
  logic [data_bits-1:0] cells [2**addr_bits];

  always_ff @(posedge clock) begin
    if (write_enable) cells[address] <= data_in;
  end

  if (read_latency == 1) begin : g_async
    assign data_out = cells[address];
  end else begin : g_pipe
    logic [data_bits-1:0] pipe [read_latency-1];
    always_ff @(posedge clock) begin
      pipe[0] <= cells[address];
      for (int i = 1; i < read_latency - 1; i++) pipe[i] <= pipe[i-1];
    end
    assign data_out = pipe[read_latency-2];
  end
endmodule

// File: rtl/cell_access_unit.sv
// One-at-a-time READ/WRITE/ADD/CLEAR sequencer in front of the single-port ram; response after
// read_latency (READ), 1 (WRITE/CLEAR) or read_latency+1 (ADD) edges, held until rsp_ready.
module cell_access_unit
  import cpu_pkg::*;
#(
  parameter int addr_bits    = ADDR_BITS,
  parameter int data_bits    = DATA_BITS,
  parameter int read_latency = 1
) (
  input  logic                 clock,
  input  logic                 reset_n,
  cell_access_unit_if.slave    bus,
  output logic [addr_bits-1:0] mem_address,
  output logic                 mem_write_enable,
  output logic [data_bits-1:0] mem_wdata,
  input  logic [data_bits-1:0] mem_rdata
);
  if (read_latency < 1 || read_latency > 15) begin : g_latency_check
    $error("cell_access_unit: read_latency must be within 1..15");
  end

  typedef enum logic [1:0] {IDLE, READ_WAIT, WRITE, RESP} state_e;

  state_e               state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [1:0]           op_q, op_d;
  logic [data_bits-1:0] data_q, data_d;
  logic [addr_bits-1:0] addr_d;
  logic                 we_d;
  logic [data_bits-1:0] wdata_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic [data_bits-1:0] rsp_data_q, rsp_data_d;
  logic                 rsp_zero_q, rsp_zero_d;

  assign bus.cmd_ready = (state_q == IDLE) && reset_n;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_zero  = rsp_zero_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    data_d      = data_q;
    addr_d      = mem_address;
    we_d        = mem_write_enable;
    wdata_d     = mem_wdata;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          op_d   = bus.cmd_op;
          data_d = bus.cmd_data;
          addr_d = bus.cmd_address;
          case (bus.cmd_op)
            OP_READ, OP_ADD: begin
              cnt_d   = 4'(read_latency);
              state_d = READ_WAIT;
            end
            OP_WRITE: begin
              wdata_d = bus.cmd_data;
              we_d    = 1'b1;
              state_d = WRITE;
            end
            default: begin
              wdata_d = '0;
              we_d    = 1'b1;
              state_d = WRITE;
            end
          endcase
        end
      end
      READ_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          // ADD turns the captured read into a one-cycle write-back of the wrapped sum
          if (op_q == OP_ADD) begin
            wdata_d = mem_rdata + data_q;
            we_d    = 1'b1;
            state_d = WRITE;
          end else begin
            rsp_data_d  = mem_rdata;
            rsp_valid_d = 1'b1;
            state_d     = RESP;
          end
        end
      end
      WRITE: begin
        we_d        = 1'b0;
        rsp_data_d  = mem_wdata;
        rsp_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    rsp_zero_d = (rsp_data_d == '0);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q          <= IDLE;
      cnt_q            <= '0;
      op_q             <= '0;
      data_q           <= '0;
      mem_address      <= '0;
      mem_write_enable <= 1'b0;
      mem_wdata        <= '0;
      rsp_valid_q      <= 1'b0;
      rsp_data_q       <= '0;
      rsp_zero_q       <= 1'b0;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      op_q             <= op_d;
      data_q           <= data_d;
      mem_address      <= addr_d;
      mem_write_enable <= we_d;
      mem_wdata        <= wdata_d;
      rsp_valid_q      <= rsp_valid_d;
      rsp_data_q       <= rsp_data_d;
      rsp_zero_q       <= rsp_zero_d;
    end
  end
endmodule

// File: tb/tb_cell_access_unit.sv
// Drives two unit+ram pairs (read_latency 1 and 3) and checks every response against a cell-array model.
module tb_cell_access_unit;
  import cpu_pkg::*;

  localparam int LAT0 = 1;
  localparam int LAT1 = 3;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  logic [1:0]       cmd_valid = '0;
  logic [1:0]       rsp_ready = '0;
  logic [1:0][1:0]  cmd_op = '0;
  logic [1:0][15:0] cmd_addr = '0;
  logic [1:0][7:0]  cmd_data = '0;
  logic [1:0]       cmd_ready, rsp_valid, rsp_zero, mem_we;
  logic [1:0][7:0]  rsp_data, mem_wdata, mem_rdata;
  logic [1:0][15:0] mem_addr;

  cell_access_unit_if #(.addr_bits(16), .data_bits(8)) bus0 ();
  cell_access_unit_if #(.addr_bits(16), .data_bits(8)) bus1 ();

  assign bus0.cmd_valid = cmd_valid[0];   assign bus1.cmd_valid = cmd_valid[1];
  assign bus0.cmd_op = cmd_op[0];         assign bus1.cmd_op = cmd_op[1];
  assign bus0.cmd_address = cmd_addr[0];  assign bus1.cmd_address = cmd_addr[1];
  assign bus0.cmd_data = cmd_data[0];     assign bus1.cmd_data = cmd_data[1];
  assign bus0.rsp_ready = rsp_ready[0];   assign bus1.rsp_ready = rsp_ready[1];
  assign cmd_ready = {bus1.cmd_ready, bus0.cmd_ready};
  assign rsp_valid = {bus1.rsp_valid, bus0.rsp_valid};
  assign rsp_zero  = {bus1.rsp_zero, bus0.rsp_zero};
  assign rsp_data  = {bus1.rsp_data, bus0.rsp_data};

  cell_access_unit #(.addr_bits(16), .data_bits(8), .read_latency(LAT0)) dut0 (
    .clock(clock), .reset_n(reset_n), .bus(bus0), .mem_address(mem_addr[0]),
    .mem_write_enable(mem_we[0]), .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata[0]));
  ram #(.addr_bits(16), .data_bits(8), .read_latency(LAT0)) ram0 (
    .clock(clock), .address(mem_addr[0]), .write_enable(mem_we[0]),
    .data_in(mem_wdata[0]), .data_out(mem_rdata[0]));

  cell_access_unit #(.addr_bits(16), .data_bits(8), .read_latency(LAT1)) dut1 (
    .clock(clock), .reset_n(reset_n), .bus(bus1), .mem_address(mem_addr[1]),
    .mem_write_enable(mem_we[1]), .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata[1]));
  ram #(.addr_bits(16), .data_bits(8), .read_latency(LAT1)) ram1 (
    .clock(clock), .address(mem_addr[1]), .write_enable(mem_we[1]),
    .data_in(mem_wdata[1]), .data_out(mem_rdata[1]));

  int checks = 0;
  int failures = 0;
  logic [7:0] model [2][256];

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int lat_of(input int k);
    return (k == 0) ? LAT0 : LAT1;
  endfunction

  task automatic chk_idle_outputs(input int k, input string tag);
    chk({tag, " rsp_valid"}, int'(rsp_valid[k]), 0);
    chk({tag, " rsp_data"}, int'(rsp_data[k]), 0);
    chk({tag, " rsp_zero"}, int'(rsp_zero[k]), 0);
    chk({tag, " mem_we"}, int'(mem_we[k]), 0);
    chk({tag, " mem_addr"}, int'(mem_addr[k]), 0);
    chk({tag, " mem_wdata"}, int'(mem_wdata[k]), 0);
    chk({tag, " cmd_ready"}, int'(cmd_ready[k]), 0);
  endtask

  // Issue one command, check latency, write pulse, response value and return to idle.
  // hold > 0 keeps rsp_ready low that many cycles while offering a second (READ) command.
  task automatic do_cmd(input int k, input logic [1:0] op, input logic [15:0] addr,
                        input logic [7:0] data, input int hold);
    int cur, exp, elat, ewe_at, n, guard, we_hi, we_at;
    string t;
    t = $sformatf("u%0d op%0d @%0h", k, op, addr);
    cur = int'(model[k][addr[7:0]]);
    ewe_at = -1;
    case (op)
      OP_READ:  begin exp = cur; elat = lat_of(k); end
      OP_WRITE: begin exp = int'(data); elat = 1; ewe_at = 0; end
      OP_ADD:   begin exp = (cur + int'($signed(data)) + 256) % 256; elat = lat_of(k) + 1; ewe_at = lat_of(k); end
      default:  begin exp = 0; elat = 1; ewe_at = 0; end
    endcase
    @(negedge clock);
    cmd_valid[k] = 1'b1; cmd_op[k] = op; cmd_addr[k] = addr; cmd_data[k] = data;
    rsp_ready[k] = (hold == 0);
    guard = 0;
    while (!cmd_ready[k] && guard < 50) begin @(negedge clock); guard++; end
    chk({t, " accept_timeout"}, guard < 50 ? 1 : 0, 1);
    @(posedge clock); #1;
    cmd_valid[k] = 1'b0;
    chk({t, " mem_addr"}, int'(mem_addr[k]), int'(addr));
    n = 0; we_hi = 0; we_at = -1;
    if (mem_we[k]) begin we_hi++; we_at = 0; end
    while (!rsp_valid[k] && n < 40) begin
      @(posedge clock); #1; n++;
      if (mem_we[k]) begin we_hi++; if (we_at < 0) we_at = n; end
    end
    chk({t, " latency"}, n, elat);
    chk({t, " rsp_data"}, int'(rsp_data[k]), exp);
    chk({t, " rsp_zero"}, int'(rsp_zero[k]), exp == 0 ? 1 : 0);
    chk({t, " we_cycles"}, we_hi, ewe_at < 0 ? 0 : 1);
    if (ewe_at >= 0) chk({t, " we_edge"}, we_at, ewe_at);
    if (op != OP_READ) model[k][addr[7:0]] = 8'(exp);
    if (hold > 0) begin
      cmd_valid[k] = 1'b1; cmd_op[k] = OP_READ;
      for (int i = 0; i < hold; i++) begin
        @(posedge clock); #1;
        chk({t, " hold rsp_valid"}, int'(rsp_valid[k]), 1);
        chk({t, " hold rsp_data"}, int'(rsp_data[k]), exp);
        chk({t, " hold cmd_ready"}, int'(cmd_ready[k]), 0);
        chk({t, " hold mem_addr"}, int'(mem_addr[k]), int'(addr));
        chk({t, " hold mem_we"}, int'(mem_we[k]), 0);
      end
      rsp_ready[k] = 1'b1;
    end
    @(posedge clock); #1;
    chk({t, " consumed rsp_valid"}, int'(rsp_valid[k]), 0);
    chk({t, " back to idle"}, int'(cmd_ready[k]), 1);
  endtask

  initial begin
    #12;
    chk_idle_outputs(0, "reset u0");
    chk_idle_outputs(1, "reset u1");
    @(negedge clock); reset_n = 1'b1;

    do_cmd(0, OP_WRITE, 16'h0010, 8'h5A, 0);
    do_cmd(0, OP_READ,  16'h0010, 8'h00, 0);
    do_cmd(0, OP_WRITE, 16'h0000, 8'hFF, 0);
    do_cmd(0, OP_ADD,   16'h0000, 8'h01, 0);
    do_cmd(0, OP_ADD,   16'h0000, 8'hFF, 0);
    do_cmd(0, OP_WRITE, 16'h0003, 8'h7E, 0);
    do_cmd(0, OP_CLEAR, 16'h0003, 8'h99, 0);
    do_cmd(0, OP_READ,  16'h0003, 8'h00, 0);
    do_cmd(0, OP_WRITE, 16'h0005, 8'h04, 0);
    do_cmd(0, OP_ADD,   16'h0005, 8'h03, 5);
    do_cmd(0, OP_READ,  16'h0005, 8'h00, 0);

    do_cmd(1, OP_WRITE, 16'h0030, 8'h22, 0);
    do_cmd(1, OP_READ,  16'h0030, 8'h00, 0);
    do_cmd(1, OP_ADD,   16'h0030, 8'h01, 0);
    do_cmd(1, OP_READ,  16'h0030, 8'h00, 0);

    // Reset while an ADD sits in READ_WAIT: the write-back must never happen.
    do_cmd(0, OP_WRITE, 16'h0020, 8'h10, 0);
    @(negedge clock);
    cmd_valid[0] = 1'b1; cmd_op[0] = OP_ADD; cmd_addr[0] = 16'h0020; cmd_data[0] = 8'h05;
    @(posedge clock); #1;
    cmd_valid[0] = 1'b0;
    #1 reset_n = 1'b0;
    #1 chk_idle_outputs(0, "abort u0");
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("abort no write pulse", int'(mem_we[0]), 0);
    end
    reset_n = 1'b1;
    #1 chk("abort cmd_ready after release", int'(cmd_ready[0]), 1);
    do_cmd(0, OP_READ, 16'h0020, 8'h00, 0);

    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 16; i++) do_cmd(k, OP_WRITE, 16'h0040 + 16'(i), 8'($urandom), 0);
      for (int n = 0; n < 40; n++) begin
        do_cmd(k, 2'($urandom_range(0, 3)), 16'h0040 + 16'($urandom_range(0, 15)), 8'($urandom),
               ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/cell_access_unit.md
Name: cell_access_unit

Overview:
- Request/response memory sequencer between the CPU core datapath and the single-port `ram` block.
- Accepts one cell command at a time: READ, WRITE, ADD (signed-delta read-modify-write) or CLEAR.
- Drives `ram` address, write enable and write data.
- Returns the resulting cell value and a zero flag, which the core uses for loop branches.

Parameters:
- addr_bits, 16, cell address width; matches ram addr_bits.
- data_bits, 8, cell width; matches ram data_bits.
- read_latency, 1, cycles from stable address to valid mem_rdata; legal range 1..15.

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  unit idle and able to accept.
- cmd_op  in  2  00 READ, 01 WRITE, 10 ADD, 11 CLEAR.
- cmd_address  in  addr_bits  target cell.
- cmd_data  in  data_bits  write value (WRITE) or two's-complement delta (ADD); ignored for READ/CLEAR.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  core consumes response.
- rsp_data  out  data_bits  cell value after the operation.
- rsp_zero  out  1  rsp_data == 0.
- mem_address  out  addr_bits  to ram address.
- mem_write_enable  out  1  to ram write_enable.
- mem_wdata  out  data_bits  to ram data_in.
- mem_rdata  in  data_bits  from ram data_out.

Behaviour:
- Reset (async assert, sync release):
  - state IDLE.
  - All outputs 0: cmd_ready, rsp_valid, rsp_data, rsp_zero, mem_address, mem_write_enable, mem_wdata.
- Output registration:
  - All outputs are registered except cmd_ready.
  - cmd_ready = (state == IDLE) and reset_n high.
- States: IDLE, READ_WAIT, WRITE, RESP.
- IDLE:
  - Accept on the edge where cmd_valid && cmd_ready (edge E0).
  - Latch op and data; mem_address <= cmd_address.
  - READ/ADD: wait counter <= read_latency, then READ_WAIT.
  - WRITE: mem_wdata <= cmd_data, mem_write_enable <= 1, then WRITE.
  - CLEAR: mem_wdata <= 0, mem_write_enable <= 1, then WRITE.
- READ_WAIT:
  - Decrement the counter each edge.
  - On the edge where the counter equals 1, capture mem_rdata.
  - READ: rsp_data <= captured value, rsp_valid <= 1, then RESP.
  - ADD: mem_wdata <= (captured + cmd_data) mod 2^data_bits, mem_write_enable <= 1, then WRITE.
- WRITE:
  - Lasts exactly one cycle.
  - Next edge: mem_write_enable <= 0, rsp_data <= mem_wdata, rsp_valid <= 1, then RESP.
- RESP:
  - rsp_valid, rsp_data and rsp_zero are held stable until rsp_ready is sampled high.
  - On that edge rsp_valid <= 0 and state returns to IDLE.
  - cmd_ready is 0 throughout RESP, so no overlap.
  - Next accept is possible one edge later.
- Latency from E0 until rsp_valid is visible:
  - READ: read_latency edges.
  - WRITE/CLEAR: 1 edge.
  - ADD: read_latency + 1 edges.
- Memory interface:
  - mem_address and mem_wdata change only on accept, or on the ADD transition into WRITE.
  - Both are stable for every cycle mem_write_enable is high.
  - mem_write_enable is never high for more than one consecutive cycle per command.
- Arithmetic: ADD wraps silently (0xFF + 1 = 0x00; 0x00 + 0xFF = 0xFF, i.e. −1). No carry or overflow output.
- rsp_zero is registered alongside rsp_data and is always consistent with it.
- cmd_valid while busy: ignored and not queued; the core must hold it until cmd_ready.
- rsp_ready while rsp_valid is low: ignored.
- Reset mid-operation:
  - Immediate abort; mem_write_enable drops asynchronously.
  - A pending ADD write is not performed.
  - A WRITE already in progress may or may not land in ram; the bench must not check that cell.
- read_latency out of range: elaboration error, checked with a generate-time assertion.

Decomposition:
- Shared package cpu_pkg holds:
  - op encodings OP_READ/OP_WRITE/OP_ADD/OP_CLEAR (2-bit);
  - default cell/address widths used by both ram and this unit.
- State encoding stays local to the module.
- No sub-module: the FSM, the latency counter (4 bits) and the adder fit in one block.
- The bench instantiates cell_access_unit + ram back to back.

Test Plan:
- Reset, then WRITE addr 0x0010 data 0x5A; READ 0x0010 -> mem_write_enable high exactly 1 cycle; WRITE rsp_data 0x5A rsp_zero 0; READ rsp_data 0x5A 1 edge after accept.
- ADD wrap-around: cell 0x0000 = 0xFF, ADD data 0x01 -> rsp_data 0x00, rsp_zero 1, rsp 2 edges after accept; then ADD 0xFF -> rsp_data 0xFF.
- CLEAR on cell 0x0003 holding 0x7E, then READ -> rsp_data 0x00, rsp_zero 1.
- Response backpressure: hold rsp_ready low 5 cycles after an ADD of 0x03 to a cell holding 0x04 -> rsp_valid and rsp_data 0x07 stable, cmd_ready 0, a second cmd_valid is not accepted; release -> IDLE next edge, then second command accepted.
- read_latency = 3 build: READ of cell holding 0x22 -> rsp_valid exactly 3 edges after accept; ADD 0x01 -> write enable exactly at edge 3, rsp 4 edges after accept, cell becomes 0x23.
- Async reset asserted during READ_WAIT of an ADD to cell 0x0020 holding 0x10 -> outputs 0 immediately, no write pulse, cell still 0x10 on a later READ.
